// File: rtl/iterative_divider_core.sv
// iterative_divider_core: restoring unsigned divider, one quotient bit per cycle; `DIVIDER_ZERO_DETECT_EN` adds a divide-by-zero bypass
module iterative_divider_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]       state;
    logic [WIDTH-1:0] a, q, m;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   pr, diff;
    logic             ge, accept;
    assign quotient  = q;
    assign remainder = a;
    // trial subtraction of the divisor from the left-shifted partial remainder
    always_comb begin
        pr     = {a, q[WIDTH-1]};
        diff   = pr - {1'b0, m};
        ge     = ~diff[WIDTH];
        accept = (state == IDLE) && start && !busy;
    end
    // control FSM and datapath; busy/done are registered copies of the state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            a     <= '0;
            q     <= '0;
            m     <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            busy <= state != IDLE;
            done <= state == DONE;
            if (accept) begin
                m   <= divisor;
                cnt <= CW'(WIDTH);
`ifdef DIVIDER_ZERO_DETECT_EN
                q     <= (divisor == '0) ? '1 : dividend;
                a     <= (divisor == '0) ? dividend : '0;
                state <= (divisor == '0) ? DONE : ITER;
`else
                q     <= dividend;
                a     <= '0;
                state <= ITER;
`endif
            end else if (state == ITER) begin
                a   <= ge ? diff[WIDTH-1:0] : pr[WIDTH-1:0];
                q   <= {q[WIDTH-2:0], ge};
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) state <= DONE;
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end
`ifdef DIVIDER_ZERO_DETECT_EN
    // zero-divisor flag: raised alongside done, held until the next accepted start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) div_by_zero <= 1'b0;
        else if (accept) div_by_zero <= 1'b0;
        else if (state == DONE) div_by_zero <= m == '0;
    end
`else
    assign div_by_zero = 1'b0;
`endif
endmodule

// File: doc/iterative_divider_core.md
ITERATIVE_DIVIDER_CORE -- requirements
Module: iterative_divider_core

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning operand, quotient and remainder width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port start  input  1  request to begin a division, sampled only in IDLE.
REQ-005 The block SHALL have port dividend  input  WIDTH  unsigned dividend, captured on accepted start.
REQ-006 The block SHALL have port divisor  input  WIDTH  unsigned divisor, captured on accepted start.
REQ-007 The block SHALL have port busy  output  1  high while a division is in progress (states ITER and DONE).
REQ-008 The block SHALL have port done  output  1  single-cycle pulse marking valid results.
REQ-009 The block SHALL have port quotient  output  WIDTH  unsigned quotient.
REQ-010 The block SHALL have port remainder  output  WIDTH  unsigned remainder.
REQ-011 The block SHALL have port div_by_zero  output  1  high with done when the captured divisor was zero.

Function
REQ-012 The block SHALL implement FSM states IDLE, ITER and DONE, with a WIDTH-bit partial remainder register A, a WIDTH-bit quotient shift register Q, a divisor register M and an iteration counter.
REQ-013 IDLE with start=1 at a rising edge SHALL capture the inputs as follows and move to ITER: M=divisor, Q=dividend, A=0, counter=WIDTH.
REQ-014 Each ITER cycle SHALL perform one restoring step.
REQ-015 Restoring step: shift {A,Q} left by one.
REQ-016 Restoring step: compute the (WIDTH+1)-bit difference A-M.
REQ-017 Restoring step: if the difference is non-negative, load it into A and set Q[0]=1; otherwise leave A unchanged and set Q[0]=0.
REQ-018 Restoring step: decrement the counter.
REQ-019 ITER SHALL move to DONE after exactly WIDTH steps, which occurs when the step taken with counter=1 completes.
REQ-020 DONE SHALL last exactly one cycle, assert done=1, and return to IDLE.
REQ-021 quotient and remainder SHALL be driven from Q and A.
REQ-022 quotient and remainder SHALL remain stable from DONE until the next accepted start.
REQ-023 Latency: start accepted at edge N SHALL give done=1 in the cycle following edge N+WIDTH+1.
REQ-024 Throughput: a new start SHALL be accepted no earlier than the first IDLE cycle after DONE.
REQ-025 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-026 Changes on dividend and divisor while busy=1 SHALL NOT affect the result.
REQ-027 done and busy SHALL be registered outputs.
REQ-028 done=1 SHALL imply busy=1 in the same cycle.
REQ-029 The result SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor for every nonzero divisor.

Reset
REQ-030 reset_n=0 SHALL asynchronously force state IDLE, A=0, Q=0, M=0, counter=0, busy=0, done=0 and div_by_zero=0, which makes quotient=0 and remainder=0.
REQ-031 Reset asserted mid-operation SHALL abort the division with no done pulse.
REQ-032 The first start SHALL be accepted at the first rising edge after reset_n deasserts.

Configuration
REQ-033 The macro DIVIDER_ZERO_DETECT_EN SHALL control divide-by-zero fast handling.
REQ-034 With DIVIDER_ZERO_DETECT_EN defined, an accepted start with divisor=0 SHALL bypass ITER and enter DONE on the next edge.
REQ-035 In that bypass case the outputs SHALL be quotient=all ones, remainder=dividend, div_by_zero=1 during DONE, and the latency SHALL be 2 cycles.
REQ-036 With DIVIDER_ZERO_DETECT_EN undefined, a zero divisor SHALL run the normal WIDTH iterations, giving quotient=all ones and remainder=dividend with the normal latency.
REQ-037 With DIVIDER_ZERO_DETECT_EN undefined, div_by_zero SHALL remain a port tied to 0.
REQ-038 div_by_zero SHALL clear on the next accepted start.

Verification
REQ-039 The bench SHALL cover: WIDTH=4, dividend=13, divisor=3, one start pulse -> done exactly 6 edges after start, quotient=4, remainder=1, busy high for 5 cycles.
REQ-040 The bench SHALL cover: exhaustive 16x15 sweep with divisor 1..15 -> quotient and remainder match the integer reference for every pair.
REQ-041 The bench SHALL cover: dividend=9, divisor=0 -> with the macro, done 2 cycles later, quotient=15, remainder=9, div_by_zero=1; without the macro, done at cycle 6, same quotient and remainder, div_by_zero=0.
REQ-042 The bench SHALL cover: start held high continuously with changing operands -> only operands captured in IDLE are used, one done per division, no back-to-back acceptance during DONE.
REQ-043 The bench SHALL cover: reset_n pulsed low during the 3rd ITER cycle of 15/2 -> outputs are 0 immediately, no done pulse, and a next start with 15/2 yields quotient=7, remainder=1.
REQ-044 The bench SHALL cover: dividend=0, divisor=5 -> quotient=0, remainder=0, done at cycle 6.
